// File: rtl/adder_word_chainer.sv
// rtl/adder_word_chainer.sv - carry-chaining stream stage around an external combinational adder
//
// Purpose:
//   Accepts operand words on a valid/ready stream and drives them to an
//   external combinational adder. The adder's sum and carry-out are captured
//   into a single registered output stage. The carry is chained between
//   consecutive words, so an N-word add runs one word per cycle, starting
//   with the least-significant word.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            operand word handshake
//   in_a, in_b, in_cin           operand words and carry-in (carry-in is used on a first word only)
//   in_first, in_last            marks the least- and most-significant words of an operation
//   add_a, add_b, add_cin        outputs to the adder
//   add_sum, add_cout            inputs from the adder
//   out_valid/out_ready          result word handshake
//   out_sum, out_cout            registered result word and its carry-out
//   out_last, out_idx            registered last flag and word index (0 = first word)
//   err, err_clr                 sticky protocol-error flag and its synchronous clear

module adder_word_chainer #(
  parameter int W     = 22,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_cin,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  output logic             add_cin,
  input  logic [W-1:0]     add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic             out_cout,
  output logic             out_last,
  output logic [IDX_W-1:0] out_idx,
  output logic             err,
  input  logic             err_clr
);

  typedef enum logic {S_IDLE, S_CHAIN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_out_valid;
  logic [W-1:0]     r_out_sum;
  logic             r_out_cout;
  logic             r_out_last;
  logic [IDX_W-1:0] r_out_idx;
  logic             r_err;
  logic             r_carry_q;
  logic [IDX_W-1:0] r_idx_q;

  logic             w_xfer_in;
  logic             w_xfer_out;
  logic             w_start;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_err_evt;

  // With a single output register, a new word is accepted only when the slot
  // is empty or is being drained in the same cycle.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_xfer_in  = in_valid && in_ready;
  assign w_xfer_out = r_out_valid && out_ready;

  // A word in IDLE always starts an operation, even when in_first is missing.
  assign w_start   = in_first || (r_state == S_IDLE);
  assign w_idx_nxt = w_start ? '0 : r_idx_q + IDX_W'(1);

  assign add_a   = in_a;
  assign add_b   = in_b;
  assign add_cin = w_start ? in_cin : r_carry_q;

  // Protocol errors: the first flag is missing in IDLE, an operation is
  // restarted mid-chain, or the index overflows without a last word.
  assign w_err_evt = w_xfer_in && (
      ((r_state == S_IDLE)  && !in_first) ||
      ((r_state == S_CHAIN) &&  in_first) ||
      ((r_state == S_CHAIN) && !in_first && !in_last && (&r_idx_q)));

  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer_in) begin
      w_state_nxt = in_last ? S_IDLE : S_CHAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_idx   <= '0;
      r_err       <= 1'b0;
      r_carry_q   <= 1'b0;
      r_idx_q     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer_in) begin
        // When a word is accepted, it also replaces a word that drains in the same cycle.
        r_out_valid <= 1'b1;
        r_out_sum   <= add_sum;
        r_out_cout  <= add_cout;
        r_out_last  <= in_last;
        r_out_idx   <= w_idx_nxt;
        r_idx_q     <= w_idx_nxt;
        r_carry_q   <= in_last ? 1'b0 : add_cout;
      end else if (w_xfer_out) begin
        r_out_valid <= 1'b0;
      end
      // An error event takes priority over err_clr in the same cycle.
      if (w_err_evt) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_last  = r_out_last;
  assign out_idx   = r_out_idx;
  assign err       = r_err;

endmodule

// File: tb/tb_adder_word_chainer.sv
// tb/tb_adder_word_chainer.sv - scoreboard bench for adder_word_chainer

module tb_adder_word_chainer;

  localparam int W     = 22;
  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic             in_first = 1'b0;
  logic             in_last = 1'b0;
  logic             in_cin = 1'b0;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic             add_cin;
  logic [W-1:0]     add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     out_sum;
  logic             out_cout;
  logic             out_last;
  logic [IDX_W-1:0] out_idx;
  logic             err;
  logic             err_clr = 1'b0;

  always #5 clk = ~clk;

  // This is the external combinational adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  adder_word_chainer #(.W(W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_last(out_last), .out_idx(out_idx),
    .err(err), .err_clr(err_clr)
  );

  typedef struct packed {
    logic [W-1:0]     sum;
    logic             cout;
    logic             last;
    logic [IDX_W-1:0] idx;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic             m_chain = 1'b0;
  logic             m_carry = 1'b0;
  logic [IDX_W-1:0] m_idx   = '0;
  logic             m_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // This monitor compares each result word once, on the negedge before the word drains.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_sum",  32'(out_sum),  32'(e.sum));
        check("out_cout", 32'(out_cout), 32'(e.cout));
        check("out_last", 32'(out_last), 32'(e.last));
        check("out_idx",  32'(out_idx),  32'(e.idx));
        check("err",      32'(err),      32'(e.err));
      end
    end
  end

  // This task presents one word and waits, with a bound, for it to be accepted.
  // The reference model is updated on the negedge before the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic first, input logic last, input logic cin);
    logic   ok;
    logic   c;
    logic   start;
    logic [W:0] full;
    exp_t   e;
    in_a = a; in_b = b; in_first = first; in_last = last; in_cin = cin;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      start = first || !m_chain;
      if (!m_chain && !first) m_err = 1'b1;
      if (m_chain && first) m_err = 1'b1;
      if (m_chain && !first && !last && m_idx == IDX_MAX) m_err = 1'b1;
      c = start ? cin : m_carry;
      full = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      m_idx   = start ? '0 : m_idx + IDX_W'(1);
      m_carry = last ? 1'b0 : full[W];
      m_chain = !last;
      e.sum = full[W-1:0]; e.cout = full[W]; e.last = last; e.idx = m_idx; e.err = m_err;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] held_sum;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_idx",   32'(out_idx),   32'd0);
    check("rst_err",       32'(err),       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // This is a single-word add that overflows the word.
    send(22'h3FFFFF, 22'h000001, 1'b1, 1'b1, 1'b0);
    drain();

    // This is a two-word chain whose carry crosses the word boundary.
    send(22'h3FFFFF, 22'h000001, 1'b1, 1'b0, 1'b0);
    send(22'h000001, 22'h000000, 1'b0, 1'b1, 1'b0);
    drain();
    check("carry_cleared", 32'(dut.r_carry_q), 32'd0);

    // This is a three-word chain built from random operands.
    for (int i = 0; i < 3; i++)
      send(W'($urandom), W'($urandom), i == 0, i == 2, 1'($urandom));
    drain();

    // This is the backpressure test: the slot is full and out_ready is low.
    out_ready = 1'b0;
    send(22'h000010, 22'h000020, 1'b1, 1'b1, 1'b1);
    held_sum = 22'h000031;
    in_a = 22'h000100; in_b = 22'h000200; in_first = 1'b1; in_last = 1'b1; in_cin = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_sum",   32'(out_sum),   32'(held_sum));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(22'h000100, 22'h000200, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("replace_valid", 32'(out_valid), 32'd1);
    drain();

    // This word is missing in_first while the block is IDLE.
    send(22'h0, 22'h0, 1'b0, 1'b1, 1'b1);
    drain();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_err = 1'b0;
    check("err_clr", 32'(err), 32'd0);

    // This is a restart mid-chain.
    send(22'h000005, 22'h000006, 1'b1, 1'b0, 1'b0);
    send(22'h000007, 22'h000008, 1'b0, 1'b0, 1'b0);
    send(22'h000009, 22'h00000A, 1'b1, 1'b1, 1'b0);
    drain();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_err = 1'b0;

    // This is a reset during CHAIN while carry_q is 1 and a word is pending.
    send(22'h3FFFFF, 22'h3FFFFF, 1'b1, 1'b0, 1'b0);
    drain();
    out_ready = 1'b0;
    send(22'h3FFFFF, 22'h000001, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    m_chain = 1'b0; m_carry = 1'b0; m_idx = '0; m_err = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(22'h0, 22'h0, 1'b1, 1'b1, 1'b0);
    drain();

    // This is an index wrap: five words without in_last.
    for (int i = 0; i < 5; i++)
      send(W'(i + 1), W'(2 * i), i == 0, 1'b0, 1'b0);
    send(22'h1, 22'h1, 1'b0, 1'b1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", $time);
    $fatal(1);
  end

endmodule

// File: doc/adder_word_chainer.md
Name: adder_word_chainer

Overview:
- Sequential front/back stage wrapped around the 22-bit prefix adder.
- Accepts a valid/ready stream of operand words, drives `a`/`b`/`cin` of an external combinational adder, and captures its `sum`/`cout` into a registered output stage.
- Carry is chained between consecutive words, so multi-word (N×22-bit) additions run one word per cycle, least-significant word first.

Parameters:
- W, 22, word width; must match the adder.
- IDX_W, 4, width of the word index counter; max words per operation = 2^IDX_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_a  in  W  operand A word.
- in_b  in  W  operand B word.
- in_first  in  1  word is the least-significant word of an operation.
- in_last  in  1  word is the most-significant word of an operation.
- in_cin  in  1  carry-in, used only on a first word.
- add_a  out  W  to adder `a`; combinational copy of in_a.
- add_b  out  W  to adder `b`; combinational copy of in_b.
- add_cin  out  1  to adder `cin`.
- add_sum  in  W  from adder `sum`.
- add_cout  in  1  from adder `cout`.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts the result word.
- out_sum  out  W  registered sum word.
- out_cout  out  1  registered carry-out of this word.
- out_last  out  1  registered copy of in_last.
- out_idx  out  IDX_W  word index within the operation, 0 = first.
- err  out  1  sticky protocol-error flag.
- err_clr  in  1  synchronous clear of err.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_sum=0, out_cout=0, out_last=0, out_idx=0, err=0, carry_q=0, idx_q=0, state=IDLE. Reset mid-operation discards the partial operation and any pending output word.
- Handshake:
  - in_ready = !out_valid || out_ready (single output register; no skid buffer).
  - Transfer in = in_valid && in_ready.
  - Transfer out = out_valid && out_ready.
  - If both happen in one cycle, the new word replaces the old one; out_valid stays 1.
  - If only out transfers, out_valid <= 0.
  - Outputs hold stable while out_valid && !out_ready.
- add_cin = in_first ? in_cin : (state==CHAIN ? carry_q : in_cin). The adder path is purely combinational. Latency from in transfer to out_valid is 1 cycle.
- On an in transfer:
  - out_sum <= add_sum, out_cout <= add_cout, out_last <= in_last.
  - out_idx <= (in_first || state==IDLE) ? 0 : idx_q+1.
  - idx_q follows out_idx.
  - carry_q <= in_last ? 0 : add_cout.
- States:
  - IDLE: waiting for a first word. In transfer with in_last=1 stays IDLE (single-word operation); otherwise go to CHAIN.
  - CHAIN: an operation is in progress. In transfer with in_last=1 goes to IDLE; otherwise stays CHAIN.
- Protocol errors (err <= 1; the word is still processed):
  - in_first=0 arriving in IDLE: the word is treated as a first word and uses in_cin.
  - in_first=1 arriving in CHAIN: the previous operation is abandoned and the word starts a new one.
  - In CHAIN, a transfer with idx_q == 2^IDX_W-1 and in_last=0: the index wraps to 0 and the state stays CHAIN.
- err_clr: err <= 0 unless an error event occurs in the same cycle, in which case set wins.
- in_first=in_last=1: single-word add, cout reported, carry_q cleared.
- No in transfer: carry_q, idx_q and state hold, even across output stalls.

Test Plan:
- Single word: a=0x3FFFFF, b=0x000001, cin=0, first=last=1, out_ready=1 → next cycle out_sum=0x000000, out_cout=1, out_last=1, out_idx=0, err=0, state IDLE.
- Two-word chain:
  - Word0 a=0x3FFFFF, b=0x000001, first=1 → out_sum=0, out_cout=1, idx=0.
  - Word1 a=0x000001, b=0x000000, last=1 → add_cin=1, out_sum=0x000002, out_cout=0, idx=1.
  - carry_q=0 afterwards.
- Backpressure:
  - Hold out_ready=0 with out_valid=1 → in_ready=0 and out_* stable for 5 cycles; a presented word is not consumed.
  - Raise out_ready with in_valid → the same-cycle replace keeps out_valid=1.
- Protocol errors:
  - Word with first=0 in IDLE and in_cin=1, a=b=0 → out_sum=1, err=1.
  - err_clr → err=0.
  - first=1 mid-CHAIN → err=1, out_idx=0.
- Reset mid-op: assert rst_n=0 during CHAIN with carry_q=1 → out_valid=0 immediately (async). Next first word with cin=0, a=b=0 → out_sum=0.
- Index wrap (IDX_W=2): 5 words without last → out_idx 0,1,2,3,0; err set at the 5th word.
